// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling ratio and frame defaults.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/baud_rate_generator.sv
// Free-running mod-M counter producing a one-clk tick every M cycles.
// Shared by the UART transmitter and receiver as their 16x oversampling strobe.
module baud_rate_generator #(
    parameter int N = 8,
    parameter int M = 163
) (
    input  logic         clk,
    input  logic         reset,
    output logic         max_tick,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] R_LAST = N'(M - 1);

    logic [N-1:0] r_q;
    logic [N-1:0] r_d;

    always_comb begin
        r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign max_tick = (r_q == R_LAST);
    assign q        = r_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, SB_TICK-long stop bit,
// every bit timed from the 16x oversampling tick; tx comes straight from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    uart_state_t     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // The done cycle is not an accept slot, so a held
                // tx_start restarts one clk after the pulse.
                if (tx_start && !done_q) begin
                    b_d     = din;
                    s_d     = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {1'b0, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + 1'b1;
                            tx_d = b_d[0];
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SB_LAST) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two transmitters (1 and 2 stop bits) on one baud generator,
// with a tick-counting line monitor that decodes frames against a byte scoreboard.
module tb_uart_tx;

    localparam int M    = 163;
    localparam int BITC = 16 * M;

    logic       clk;
    logic       rst_n;
    logic       rst2_n;
    logic       tick;
    logic [7:0] bq;
    logic       start0, start1;
    logic [7:0] din0, din1;
    logic       tx_w   [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       rstc   [2];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    baud_rate_generator #(.N(8), .M(M)) u_baud (
        .clk      (clk),
        .reset    (rst_n),
        .max_tick (tick),
        .q        (bq)
    );

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut0 (
        .clk          (clk),
        .reset        (rst_n),
        .s_tick       (tick),
        .tx_start     (start0),
        .din          (din0),
        .tx           (tx_w[0]),
        .tx_busy      (busy_w[0]),
        .tx_done_tick (done_w[0])
    );

    uart_tx #(.DBIT(8), .SB_TICK(32)) dut1 (
        .clk          (clk),
        .reset        (rst2_n),
        .s_tick       (tick),
        .tx_start     (start1),
        .din          (din1),
        .tx           (tx_w[1]),
        .tx_busy      (busy_w[1]),
        .tx_done_tick (done_w[1])
    );

    assign rstc[0] = rst_n;
    assign rstc[1] = rst2_n;

    // Scoreboards: bytes expected on each line, in order.
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int   sbt [2] = '{16, 32};
    int   cyc = 0;
    bit   on    [2];
    bit   first [2];
    bit   bad   [2];
    bit   pend  [2];
    int   tcnt  [2];
    int   bidx  [2];
    int   bstart[2];
    int   dcnt  [2];
    int   done_cyc[2];
    int   fall_cyc[2];
    int   rise_cyc[2];
    logic bval  [2];
    logic prev_tx[2];
    logic [7:0] shr[2];

    always @(negedge clk) begin
        int lim;
        int len;
        bit ok;
        bit have;
        logic [7:0] expb;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            if (!rstc[ch]) begin
                on[ch]   = 1'b0;
                pend[ch] = 1'b0;
            end else begin
                if (prev_tx[ch] === 1'b0 && tx_w[ch] === 1'b1)
                    rise_cyc[ch] = cyc;
                if (done_w[ch] === 1'b1) begin
                    dcnt[ch]++;
                    done_cyc[ch] = cyc;
                end
                if (pend[ch]) begin
                    pend[ch] = 1'b0;
                    n_checks++;
                    if (done_w[ch] !== 1'b1 || busy_w[ch] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL done_pulse ch%0d: done=%b busy=%b, required done=1 busy=0",
                                 ch, done_w[ch], busy_w[ch]);
                    end
                    have = 1'b0;
                    expb = '0;
                    if (ch == 0 && q0.size() > 0) begin
                        expb = q0.pop_front();
                        have = 1'b1;
                    end
                    if (ch == 1 && q1.size() > 0) begin
                        expb = q1.pop_front();
                        have = 1'b1;
                    end
                    n_checks++;
                    if (!have || shr[ch] !== expb) begin
                        n_fail++;
                        $display("FAIL frame_data ch%0d: got %02h, required %02h (queued=%0d)",
                                 ch, shr[ch], expb, have);
                    end
                end else if (done_w[ch] === 1'b1) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stray_done ch%0d: done=1 at cycle %0d, required 0", ch, cyc);
                end
                if (!on[ch] && tx_w[ch] === 1'b0) begin
                    on[ch]       = 1'b1;
                    first[ch]    = 1'b1;
                    tcnt[ch]     = 0;
                    bidx[ch]     = 0;
                    bstart[ch]   = cyc;
                    bad[ch]      = 1'b0;
                    shr[ch]      = '0;
                    fall_cyc[ch] = cyc;
                end
                if (on[ch]) begin
                    if (first[ch]) begin
                        bval[ch]  = tx_w[ch];
                        first[ch] = 1'b0;
                    end else if (tx_w[ch] !== bval[ch]) begin
                        bad[ch] = 1'b1;
                    end
                    if (tick === 1'b1) begin
                        tcnt[ch]++;
                        lim = (bidx[ch] == 9) ? sbt[ch] : 16;
                        if (tcnt[ch] == lim) begin
                            len = cyc - bstart[ch] + 1;
                            if (bidx[ch] == 0) begin
                                ok = (len > 15 * M) && (len <= 16 * M) && (bval[ch] === 1'b0);
                            end else if (bidx[ch] == 9) begin
                                ok = (len == sbt[ch] * M) && (bval[ch] === 1'b1);
                            end else begin
                                ok = (len == BITC);
                                shr[ch] = {bval[ch], shr[ch][7:1]};
                            end
                            n_checks++;
                            if (bad[ch] || !ok) begin
                                n_fail++;
                                $display("FAIL bit%0d ch%0d: value=%b len=%0d glitch=%0d, required steady bit of nominal length",
                                         bidx[ch], ch, bval[ch], len, bad[ch]);
                            end
                            bidx[ch]++;
                            tcnt[ch]   = 0;
                            first[ch]  = 1'b1;
                            bad[ch]    = 1'b0;
                            bstart[ch] = cyc + 1;
                            if (bidx[ch] == 10) begin
                                on[ch]   = 1'b0;
                                pend[ch] = 1'b1;
                            end
                        end
                    end
                end
            end
            prev_tx[ch] = tx_w[ch];
        end
    end

    task automatic test_reset();
        int badc;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        din0   = '0;
        din1   = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state0: tx=%b busy=%b done=%b, required 1 0 0",
                     tx_w[0], busy_w[0], done_w[0]);
        end
        n_checks++;
        if (tx_w[1] !== 1'b1 || busy_w[1] !== 1'b0 || done_w[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state1: tx=%b busy=%b done=%b, required 1 0 0",
                     tx_w[1], busy_w[1], done_w[1]);
        end
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        badc   = 0;
        repeat (5000) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || tx_w[1] !== 1'b1 || busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0)
                badc++;
        end
        n_checks++;
        if (badc != 0 || dcnt[0] != 0 || dcnt[1] != 0) begin
            n_fail++;
            $display("FAIL idle_line: %0d bad cycles, %0d/%0d done pulses, required 0",
                     badc, dcnt[0], dcnt[1]);
        end
    endtask

    task automatic test_single_frame();
        int d0;
        int k;
        d0 = dcnt[0];
        q0.push_back(8'hA5);
        din0   = 8'hA5;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        din0   = 8'($urandom);
        n_checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: tx=%b busy=%b, required tx=0 busy=1", tx_w[0], busy_w[0]);
        end
        // A second request lands mid-way through the 0xA5 frame.
        repeat (5 * BITC) @(negedge clk);
        din0   = 8'h3C;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n_checks++;
        if (busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_hold: busy=%b, required 1", busy_w[0]);
        end
        k = 0;
        while (dcnt[0] == d0 && k < 12 * BITC) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (dcnt[0] == d0) begin
            n_fail++;
            $display("FAIL single_timeout: no done after %0d cycles, required one", k);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (dcnt[0] != d0 + 1 || on[0] || tx_w[0] !== 1'b1 || q0.size() != 0) begin
            n_fail++;
            $display("FAIL busy_reject: done=%0d active=%0d tx=%b left=%0d, required 1 0 1 0",
                     dcnt[0] - d0, on[0], tx_w[0], q0.size());
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int k;
        d0 = dcnt[0];
        q0.push_back(8'h00);
        q0.push_back(8'hFF);
        din0   = 8'h00;
        start0 = 1'b1;
        @(negedge clk);
        din0 = 8'hFF;
        n_checks++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: tx=%b busy=%b, required tx=0 busy=1", tx_w[0], busy_w[0]);
        end
        k = 0;
        while (dcnt[0] == d0 && k < 12 * BITC) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!on[0] && k < 10) begin
            @(negedge clk);
            k++;
        end
        start0 = 1'b0;
        n_checks++;
        if (dcnt[0] != d0 + 1 || fall_cyc[0] != done_cyc[0] + 2) begin
            n_fail++;
            $display("FAIL b2b_gap: done=%0d fall-done=%0d, required 1 and 2",
                     dcnt[0] - d0, fall_cyc[0] - done_cyc[0]);
        end
        k = 0;
        while (dcnt[0] < d0 + 2 && k < 12 * BITC) begin
            @(negedge clk);
            k++;
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (dcnt[0] != d0 + 2 || on[0] || q0.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_frames: done=%0d active=%0d left=%0d, required 2 0 0",
                     dcnt[0] - d0, on[0], q0.size());
        end
    endtask

    task automatic test_stop_len();
        int d1;
        int k;
        d1 = dcnt[1];
        q1.push_back(8'h55);
        din1   = 8'h55;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (dcnt[1] == d1 && k < 13 * BITC) begin
            @(negedge clk);
            k++;
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (dcnt[1] != d1 + 1 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL stop_frame: done=%0d left=%0d, required 1 0", dcnt[1] - d1, q1.size());
        end
        n_checks++;
        if (done_cyc[1] - rise_cyc[1] != 32 * M) begin
            n_fail++;
            $display("FAIL stop_len: %0d clk, required %0d", done_cyc[1] - rise_cyc[1], 32 * M);
        end
    endtask

    task automatic test_mid_reset();
        int d1;
        int k;
        d1 = dcnt[1];
        din1   = 8'h35;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (!(on[1] && bidx[1] == 4) && k < 6 * BITC) begin
            @(negedge clk);
            k++;
        end
        repeat (8 * M) @(negedge clk);
        n_checks++;
        if (tx_w[1] !== 1'b0 || busy_w[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_abort: tx=%b busy=%b, required data bit 3 (0) and busy", tx_w[1], busy_w[1]);
        end
        #1 rst2_n = 1'b0;
        #1;
        n_checks++;
        if (tx_w[1] !== 1'b1 || busy_w[1] !== 1'b0 || done_w[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: tx=%b busy=%b done=%b, required 1 0 0",
                     tx_w[1], busy_w[1], done_w[1]);
        end
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (dcnt[1] != d1 || on[1] || tx_w[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_quiet: done=%0d active=%0d tx=%b, required 0 0 1",
                     dcnt[1] - d1, on[1], tx_w[1]);
        end
        q1.push_back(8'hC3);
        din1   = 8'hC3;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (dcnt[1] == d1 && k < 13 * BITC) begin
            @(negedge clk);
            k++;
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (dcnt[1] != d1 + 1 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL after_reset_frame: done=%0d left=%0d, required 1 0", dcnt[1] - d1, q1.size());
        end
    endtask

    initial begin
        test_reset();
        fork
            begin
                test_single_frame();
                test_back_to_back();
            end
            begin
                test_stop_len();
                test_mid_reset();
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
